// File: rtl/cnn_sched_pkg.sv
// rtl/cnn_sched_pkg.sv - shared state encoding, read latency and ReLU helper for the channel scheduler
package cnn_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DRAIN,
        ST_NEXT,
        ST_DONE
    } sched_state_t;

    // Core result buffer returns data this many cycles after the read enable.
    localparam int READ_LATENCY = 1;

    // ReLU on a two's-complement word reduces to a keep/zero decision on its sign bit.
    function automatic logic relu_keep(input logic sign_bit);
        return !sign_bit;
    endfunction

endpackage

// File: rtl/sched_hold_reg.sv
// rtl/sched_hold_reg.sv - one-entry hold register between core result reads and the drain destinations
module sched_hold_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  pop,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] data
);

    // Loads only happen when empty (reads are gated on !full), so load and pop never collide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full <= 1'b0;
            data <= '0;
        end else if (load) begin
            full <= 1'b1;
            data <= load_data;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/cnn_channel_scheduler.sv
// rtl/cnn_channel_scheduler.sv - per-channel start/drain sequencer for the CNN core; CNN_SCHED_RELU_EN applies ReLU to final outputs
module cnn_channel_scheduler
    import cnn_sched_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int CH_CNT_WIDTH  = 8,
    parameter int RES_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     job_valid,
    output logic                     job_ready,
    input  logic [CH_CNT_WIDTH-1:0]  job_channels,
    input  logic [RES_CNT_WIDTH-1:0] job_results,
    output logic                     cnn_start,
    output logic                     cnn_psum_mode,
    input  logic                     cnn_result_empty,
    input  logic                     cnn_result_valid,
    input  logic [DATA_WIDTH-1:0]    cnn_result_out,
    output logic                     cnn_result_ren,
    output logic [DATA_WIDTH-1:0]    psum_data,
    output logic                     psum_wen,
    input  logic                     psum_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     job_done,
    output logic                     job_error
);

    sched_state_t             state;
    logic [CH_CNT_WIDTH-1:0]  ch_total;
    logic [CH_CNT_WIDTH-1:0]  ch_idx;
    logic [RES_CNT_WIDTH-1:0] res_total;
    logic [RES_CNT_WIDTH-1:0] res_cnt;
    logic [RES_CNT_WIDTH-1:0] issued;
    logic                     read_pending;
    logic                     hold_full;
    logic [DATA_WIDTH-1:0]    hold_data;
    logic                     in_drain;
    logic                     is_last;
    logic                     hold_load;
    logic                     xfer;

    assign in_drain  = (state == ST_DRAIN);
    assign is_last   = (ch_idx == ch_total - CH_CNT_WIDTH'(1));
    assign hold_load = cnn_result_valid & read_pending;

    assign cnn_result_ren = in_drain & !cnn_result_empty & !hold_full & !read_pending
                            & (issued < res_total);

    // The held word goes to exactly one destination, chosen by whether this is the last pass.
    assign psum_wen  = in_drain & hold_full & !is_last & psum_ready;
    assign out_valid = in_drain & hold_full & is_last;
    assign xfer      = psum_wen | (out_valid & out_ready);
    assign psum_data = hold_data;

`ifdef CNN_SCHED_RELU_EN
    assign out_data = relu_keep(hold_data[DATA_WIDTH-1]) ? hold_data : '0;
`else
    assign out_data = hold_data;
`endif

    sched_hold_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_hold (
        .clk      (clk),
        .reset    (reset),
        .load     (hold_load),
        .load_data(cnn_result_out),
        .pop      (xfer),
        .full     (hold_full),
        .data     (hold_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            ch_total      <= '0;
            ch_idx        <= '0;
            res_total     <= '0;
            res_cnt       <= '0;
            issued        <= '0;
            read_pending  <= 1'b0;
            job_ready     <= 1'b1;
            busy          <= 1'b0;
            cnn_start     <= 1'b0;
            cnn_psum_mode <= 1'b0;
            job_done      <= 1'b0;
            job_error     <= 1'b0;
        end else begin
            cnn_start <= 1'b0;
            job_done  <= 1'b0;
            job_error <= 1'b0;

            if (cnn_result_ren) begin
                read_pending <= 1'b1;
                issued       <= issued + RES_CNT_WIDTH'(1);
            end else if (hold_load) begin
                read_pending <= 1'b0;
            end

            if (xfer) begin
                res_cnt <= res_cnt + RES_CNT_WIDTH'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (job_valid && job_ready) begin
                        ch_total  <= job_channels;
                        res_total <= job_results;
                        ch_idx    <= '0;
                        res_cnt   <= '0;
                        issued    <= '0;
                        job_ready <= 1'b0;
                        busy      <= 1'b1;
                        // Empty jobs finish without ever starting the core.
                        if (job_channels == '0 || job_results == '0) begin
                            job_error <= 1'b1;
                            job_done  <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            cnn_start     <= 1'b1;
                            cnn_psum_mode <= 1'b0;
                            state         <= ST_START;
                        end
                    end
                end
                ST_START: begin
                    state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (xfer && (res_cnt + RES_CNT_WIDTH'(1) == res_total)) begin
                        state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (is_last) begin
                        job_done <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        ch_idx        <= ch_idx + CH_CNT_WIDTH'(1);
                        res_cnt       <= '0;
                        issued        <= '0;
                        cnn_start     <= 1'b1;
                        cnn_psum_mode <= 1'b1;
                        state         <= ST_START;
                    end
                end
                ST_DONE: begin
                    job_ready     <= 1'b1;
                    busy          <= 1'b0;
                    cnn_psum_mode <= 1'b0;
                    state         <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_channel_scheduler.sv
// tb/tb_cnn_channel_scheduler.sv - randomized self-checking bench with a job-level reference model
module tb_cnn_channel_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [7:0]  job_channels = '0;
    logic [15:0] job_results = '0;
    logic        cnn_start;
    logic        cnn_psum_mode;
    logic        cnn_result_empty = 1'b1;
    logic        cnn_result_valid = 1'b0;
    logic [7:0]  cnn_result_out = '0;
    logic        cnn_result_ren;
    logic [7:0]  psum_data;
    logic        psum_wen;
    logic        psum_ready = 1'b1;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        job_done;
    logic        job_error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] job_words [0:63];
    int         cur_res = 0;
    int         core_pass = 0;
    logic [7:0] core_q [$];
    logic       mode_q [$];
    logic [7:0] psum_q [$];
    logic [7:0] out_q [$];
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         done_cycle = 0;
    int         accept_cycle = 0;
    int         last_out_cycle = 0;
    bit         rand_ready = 0;
    bit         rand_empty = 0;

    cnn_channel_scheduler dut (
        .clk             (clk),
        .reset           (reset),
        .job_valid       (job_valid),
        .job_ready       (job_ready),
        .job_channels    (job_channels),
        .job_results     (job_results),
        .cnn_start       (cnn_start),
        .cnn_psum_mode   (cnn_psum_mode),
        .cnn_result_empty(cnn_result_empty),
        .cnn_result_valid(cnn_result_valid),
        .cnn_result_out  (cnn_result_out),
        .cnn_result_ren  (cnn_result_ren),
        .psum_data       (psum_data),
        .psum_wen        (psum_wen),
        .psum_ready      (psum_ready),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .busy            (busy),
        .job_done        (job_done),
        .job_error       (job_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] exp_out(input logic [7:0] w);
`ifdef CNN_SCHED_RELU_EN
        return ($signed(w) < 0) ? 8'd0 : w;
`else
        return w;
`endif
    endfunction

    // Core model plus observer: each start loads one pass worth of words, each read answers next cycle.
    initial begin : core_and_monitor
        logic ren_now;
        logic start_now;
        forever begin
            @(negedge clk);
            ren_now   = 1'b0;
            start_now = 1'b0;
            if (!reset) begin
                ren_now   = cnn_result_ren;
                start_now = cnn_start;
                if (cnn_start) mode_q.push_back(cnn_psum_mode);
                if (psum_wen) psum_q.push_back(psum_data);
                if (out_valid && out_ready) begin
                    out_q.push_back(out_data);
                    last_out_cycle = cyc;
                end
                if (job_done) begin
                    done_cnt++;
                    done_cycle = cyc;
                end
                if (job_error) err_cnt++;
                if (job_valid && job_ready) accept_cycle = cyc;
            end
            @(posedge clk);
            #1;
            if (reset) begin
                core_q.delete();
                core_pass        = 0;
                cnn_result_valid = 1'b0;
                cnn_result_empty = 1'b1;
            end else begin
                if (start_now) begin
                    for (int k = 0; k < cur_res; k++) core_q.push_back(job_words[core_pass*cur_res + k]);
                    core_pass++;
                end
                if (ren_now && core_q.size() > 0) begin
                    cnn_result_valid = 1'b1;
                    cnn_result_out   = core_q.pop_front();
                end else begin
                    cnn_result_valid = 1'b0;
                end
                cnn_result_empty = (core_q.size() == 0) || (rand_empty && $urandom_range(0, 2) == 0);
            end
        end
    end

    initial begin : ready_randomizer
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) begin
                out_ready  = ($urandom_range(0, 1) == 1);
                psum_ready = ($urandom_range(0, 1) == 1);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) job_words[i] = 8'($urandom);
    endtask

    task automatic start_job(input int ch, input int res);
        bit got;
        got       = 0;
        cur_res   = res;
        core_pass = 0;
        mode_q.delete();
        psum_q.delete();
        out_q.delete();
        done_cnt     = 0;
        err_cnt      = 0;
        accept_cycle = -1;
        @(posedge clk);
        #1;
        job_channels = ch[7:0];
        job_results  = res[15:0];
        job_valid    = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (job_ready) got = 1;
        end
        @(posedge clk);
        #1;
        job_valid = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL accept: job_ready=%0b required 1", job_ready);
        end
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) @(negedge clk);
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL done_timeout: job_done count=%0d required 1 within %0d cycles", done_cnt, budget);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (job_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_done: job_ready=%0b busy=%0b required 1 0", job_ready, busy);
        end
    endtask

    task automatic check_job(input int ch, input int res);
        int bad;
        checks++;
        if (mode_q.size() != ch) begin
            errors++;
            $display("FAIL start_count: got %0d required %0d", mode_q.size(), ch);
        end
        bad = 0;
        for (int i = 0; i < mode_q.size(); i++) if (mode_q[i] !== (i != 0)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL psum_mode: %0d passes with wrong mode, required 0 then 1s", bad);
        end
        checks++;
        if (psum_q.size() != (ch-1)*res) begin
            errors++;
            $display("FAIL psum_count: got %0d required %0d", psum_q.size(), (ch-1)*res);
        end
        bad = 0;
        for (int i = 0; i < psum_q.size() && i < (ch-1)*res; i++) if (psum_q[i] !== job_words[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL psum_data: %0d words differ from model", bad);
        end
        checks++;
        if (out_q.size() != res) begin
            errors++;
            $display("FAIL out_count: got %0d required %0d", out_q.size(), res);
        end
        bad = 0;
        for (int i = 0; i < out_q.size() && i < res; i++)
            if (out_q[i] !== exp_out(job_words[(ch-1)*res + i])) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL out_data: %0d words differ from model", bad);
        end
        checks++;
        if (done_cycle - last_out_cycle != 2) begin
            errors++;
            $display("FAIL done_latency: got %0d cycles required 2", done_cycle - last_out_cycle);
        end
        checks++;
        if (err_cnt != 0) begin
            errors++;
            $display("FAIL spurious_error: job_error pulses=%0d required 0", err_cnt);
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if ({job_ready, busy, cnn_start, cnn_psum_mode, cnn_result_ren, psum_wen, out_valid, job_done, job_error}
            !== 9'b1_0000_0000) begin
            errors++;
            $display("FAIL %s_ctrl: got %b required 100000000", tag,
                     {job_ready, busy, cnn_start, cnn_psum_mode, cnn_result_ren, psum_wen, out_valid, job_done, job_error});
        end
        checks++;
        if (out_data !== 8'd0 || psum_data !== 8'd0) begin
            errors++;
            $display("FAIL %s_data: out_data=%0h psum_data=%0h required 0 0", tag, out_data, psum_data);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset_held");
        @(posedge clk);
        #3;
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("reset_released");
    endtask

    task automatic test_single_channel();
        job_words[0] = 8'd5;
        job_words[1] = 8'hFD;
        job_words[2] = 8'd7;
        job_words[3] = 8'd0;
        start_job(1, 4);
        wait_done(200);
        check_job(1, 4);
    endtask

    task automatic test_multi_channel();
        fill_random(6);
        start_job(3, 2);
        // A descriptor offered mid-job must be ignored; channels=0 would otherwise raise job_error.
        job_channels = 8'd0;
        job_valid    = 1'b1;
        repeat (4) @(negedge clk);
        job_valid = 1'b0;
        wait_done(300);
        check_job(3, 2);
    endtask

    task automatic test_out_backpressure();
        bit         seen;
        int         bad;
        logic [7:0] held;
        seen = 0;
        fill_random(3);
        out_ready = 1'b0;
        start_job(1, 3);
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL out_valid_timeout: out_valid=%0b required 1", out_valid);
        end
        held = out_data;
        checks++;
        if (held !== exp_out(job_words[0])) begin
            errors++;
            $display("FAIL first_out: got %0h required %0h", held, exp_out(job_words[0]));
        end
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== held || cnn_result_ren !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL out_hold: %0d stalled cycles unstable or reading, required 0", bad);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_done(200);
        check_job(1, 3);
    endtask

    task automatic test_psum_backpressure();
        bit seen;
        int bad;
        seen = 0;
        fill_random(6);
        psum_ready = 1'b0;
        start_job(2, 3);
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (cnn_result_ren) seen = 1;
        end
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (psum_wen !== 1'b0 || cnn_result_ren !== 1'b0) bad++;
        end
        checks++;
        if (!seen || bad != 0) begin
            errors++;
            $display("FAIL psum_stall: read_seen=%0b bad_cycles=%0d required 1 0", seen, bad);
        end
        @(posedge clk);
        #1;
        psum_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (psum_wen !== 1'b1) begin
            errors++;
            $display("FAIL psum_resume: psum_wen=%0b required 1", psum_wen);
        end
        wait_done(200);
        check_job(2, 3);
    endtask

    task automatic test_zero_jobs();
        for (int t = 0; t < 2; t++) begin
            if (t == 0) start_job(0, 5);
            else start_job(3, 0);
            wait_done(20);
            checks++;
            if (done_cycle != accept_cycle + 1 || err_cnt != 1 || mode_q.size() != 0) begin
                errors++;
                $display("FAIL zero_job%0d: done_lat=%0d errors=%0d starts=%0d required 1 1 0",
                         t, done_cycle - accept_cycle, err_cnt, mode_q.size());
            end
        end
    endtask

    task automatic test_reset_mid_job();
        bit seen;
        seen = 0;
        fill_random(3);
        out_ready = 1'b0;
        start_job(1, 3);
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("reset_mid_job");
        @(posedge clk);
        #3;
        reset     = 1'b0;
        out_ready = 1'b1;
        fill_random(4);
        start_job(2, 2);
        wait_done(200);
        check_job(2, 2);
    endtask

    task automatic test_random_back_to_back();
        int ch;
        int res;
        rand_ready = 1;
        rand_empty = 1;
        for (int j = 0; j < 6; j++) begin
            ch  = $urandom_range(1, 4);
            res = $urandom_range(1, 6);
            fill_random(ch * res);
            start_job(ch, res);
            wait_done(3000);
            check_job(ch, res);
        end
        rand_ready = 0;
        rand_empty = 0;
        @(negedge clk);
        out_ready  = 1'b1;
        psum_ready = 1'b1;
    endtask

    initial begin : main
        test_reset();
        test_single_channel();
        test_multi_channel();
        test_out_backpressure();
        test_psum_backpressure();
        test_zero_jobs();
        test_reset_mid_job();
        test_random_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cnn_channel_scheduler.md
# cnn_channel_scheduler

Sequences the CNN accelerator core across the input channels of one convolution job. Each channel pass issues a `start`: the first pass runs with `psum_mode=0`, later passes with `psum_mode=1`. After every pass the block drains the core's result buffer. Non-final partial sums go back into the core's psum buffer; final-channel results go to a downstream valid/ready stream. It sits between the job host and the CNN top and owns the core's `start`, `psum_mode`, result-read and psum-write pins.

## Interface
- `DATA_WIDTH`, 8, width of result, psum and output data
- `CH_CNT_WIDTH`, 8, width of channel count
- `RES_CNT_WIDTH`, 16, width of per-pass result count
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `job_valid` in 1: job descriptor offered
- `job_ready` out 1: high only in IDLE
- `job_channels` in CH_CNT_WIDTH: number of channel passes
- `job_results` in RES_CNT_WIDTH: results produced per pass
- `cnn_start` out 1: one-cycle start pulse to core
- `cnn_psum_mode` out 1: 0 on first pass, 1 on later passes; stable for the whole pass
- `cnn_result_empty` in 1: core result buffer empty
- `cnn_result_valid` in 1: read data valid, one cycle after `cnn_result_ren`
- `cnn_result_out` in DATA_WIDTH: read data
- `cnn_result_ren` out 1: result buffer read enable
- `psum_data` out DATA_WIDTH: recirculated partial sum
- `psum_wen` out 1: psum buffer write
- `psum_ready` in 1: psum buffer can accept
- `out_data` out DATA_WIDTH: final result
- `out_valid` out 1: final result offered
- `out_ready` in 1: downstream accept
- `busy` out 1: high in every state except IDLE
- `job_done` out 1: one-cycle pulse at job end
- `job_error` out 1: one-cycle pulse when `job_channels==0` or `job_results==0`

## Operation
- States: IDLE, START, DRAIN, NEXT, DONE.
- IDLE: `job_valid & job_ready` latches `job_channels` and `job_results`, then clears `ch_idx` and `res_cnt`.
  - If either latched field is 0: pulse `job_error` and go to DONE without touching the core.
  - Otherwise go to START.
- START: assert `cnn_start` for exactly one cycle. `cnn_psum_mode = (ch_idx != 0)`. Go to DRAIN.
- DRAIN: a one-entry hold register (`hold_full`) buffers one read word.
  - `cnn_result_ren = !cnn_result_empty & !hold_full & !read_pending & (issued < job_results)`.
  - A read marks `read_pending`.
  - When `cnn_result_valid` arrives: load the hold register, set `hold_full`, clear `read_pending`.
  - If `cnn_result_valid` arrives with no read pending, ignore it.
- Draining the hold register:
  - Non-last pass (`ch_idx != job_channels-1`): `psum_wen = hold_full & psum_ready`, `psum_data` = hold value.
  - Last pass: `out_valid = hold_full`; the transfer completes on `out_valid & out_ready`.
  - A completed transfer clears `hold_full` and increments `res_cnt`.
- When `res_cnt == job_results`: go to NEXT.
- NEXT: if `ch_idx == job_channels-1` go to DONE; otherwise increment `ch_idx`, clear counters, go to START.
- DONE: pulse `job_done` for one cycle, return to IDLE.
- Counters are unsigned. `ch_idx` never exceeds `job_channels-1`; no wrap is possible.
- `out_data` and `out_valid` are held stable until accepted.

## Timing
- Reset values: every output 0, except `job_ready` = 1. State IDLE; `hold_full`, `read_pending` and all counters 0.
- Reset asserted mid-job drops to IDLE immediately. Any word in the hold register is lost; the host must also reset the core.
- Job accept to `cnn_start`: 1 cycle. Last transfer to `job_done`: 2 cycles (NEXT, DONE).
- Read throughput: at most one word every 2 cycles (ren, then valid); drain takes at least one more cycle.
- `job_ready` is low from the accept cycle until the cycle after `job_done`. Descriptors offered while busy are not accepted.
- Core `start` handling is fire-and-forget. The core's `stall_signal` is not consumed; flow control is carried entirely by `cnn_result_empty`.

## Configuration
- `CNN_SCHED_RELU_EN` defined: final-pass `out_data` passes through ReLU. `out_data` is treated as signed; negative values become 0. Psum recirculation is never modified.
- Undefined: `out_data` equals the hold register value unchanged.

## Structure
- Package `cnn_sched_pkg`: state encoding (5 states), ReLU function, `READ_LATENCY = 1` constant.
- Sub-module `sched_hold_reg`: one-entry hold register with `load`, `pop`, `full` and `data`. Muxing between the psum and output destinations stays in the parent.

## Test plan
- channels=1, results=4, core returns 5, -3, 7, 0 → no `psum_wen`. `out_data` 5, -3, 7, 0 (with `CNN_SCHED_RELU_EN`: 5, 0, 7, 0). `job_done` 2 cycles after the last accept.
- channels=3, results=2 → three `cnn_start` pulses with `psum_mode` 0, 1, 1. 4 `psum_wen` writes, then 2 `out_valid` transfers.
- `out_ready` held low 10 cycles on the last pass → `out_data` stable and `cnn_result_ren` low while the hold register is full, with at most 1 word held.
- `job_channels=0` → `job_error` pulse, no `cnn_start`, `job_done` next cycle, `job_ready` high again.
- `reset` asserted in DRAIN with `hold_full=1` → next cycle: all outputs at reset values, `job_ready=1`. A new job starts with `psum_mode=0`.
- `psum_ready` low 5 cycles with the result buffer non-empty → `psum_wen` stays low and no second read is issued. Writes resume the cycle `psum_ready` rises.
